// File: rtl/drv_ad56x3.sv
// drv_ad56x3: AD56x3 dual-channel SPI DAC driver; each accepted ce sends a channel A frame, a SYNC-high gap, then a channel B frame.
module drv_ad56x3 #(
  parameter string SIGN_A        = "UNSIGNED",
  parameter string SIGN_B        = "SIGNED",
  parameter int    DATA_WIDTH    = 14,
  parameter int    SCLK_DIVIDER  = 2,
  parameter int    SYNC_DURATION = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] dataA,
  input  logic [DATA_WIDTH-1:0] dataB,
  output logic                  dacSync,
  output logic                  dacSclk,
  output logic                  dacDin
);
  localparam logic [2:0] COMMAND_WORD_A = 3'b000;
  localparam logic [2:0] ADDRESS_WORD_A = 3'b000;
  localparam logic [2:0] COMMAND_WORD_B = 3'b010;
  localparam logic [2:0] ADDRESS_WORD_B = 3'b001;
  localparam int SHIFT_WIDTH = 24;
  localparam int HALF = SCLK_DIVIDER / 2;
  localparam int DW = HALF > 1 ? $clog2(HALF) : 1;
  localparam int GAP_HALVES = 2 * SYNC_DURATION;
  localparam int HW = GAP_HALVES > 50 ? $clog2(GAP_HALVES) : 6;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);
  localparam logic [HW-1:0] FRAME_LAST = HW'(2 * (SHIFT_WIDTH + 1) - 1);
  localparam logic [HW-1:0] GAP_LAST = HW'(GAP_HALVES - 1);
  localparam bit INV_A = SIGN_A == "SIGNED";
  localparam bit INV_B = SIGN_B == "SIGNED";

  typedef enum logic [1:0] {IDLE, FRAME_A, GAP, FRAME_B} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [HW-1:0]          half_q, half_d, half_n;
  logic [SHIFT_WIDTH-1:0] sh_q, sh_d, shb_q, shb_d;
  logic                   sclk_q, sclk_d, sync_q, sync_d, tick;
  logic [DATA_WIDTH-1:0]  conv_a, conv_b;
  logic [SHIFT_WIDTH-1:0] frame_a, frame_b;

  assign conv_a  = dataA ^ {INV_A, {(DATA_WIDTH-1){1'b0}}};
  assign conv_b  = dataB ^ {INV_B, {(DATA_WIDTH-1){1'b0}}};
  assign frame_a = {2'b00, COMMAND_WORD_A, ADDRESS_WORD_A, 16'(conv_a) << (16 - DATA_WIDTH)};
  assign frame_b = {2'b00, COMMAND_WORD_B, ADDRESS_WORD_B, 16'(conv_b) << (16 - DATA_WIDTH)};
  assign tick    = div_q == DIV_LAST;
  assign half_n  = half_q + 1'b1;

  // Each frame is 50 SCLK half-periods: two of setup, then low/high pairs; data shifts on each rising half.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    half_d  = half_q;
    sh_d    = sh_q;
    shb_d   = shb_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    if (state_q == IDLE) begin
      if (ce) begin
        state_d = FRAME_A;
        sync_d  = 1'b0;
        sclk_d  = 1'b1;
        sh_d    = frame_a;
        shb_d   = frame_b;
        div_d   = '0;
        half_d  = '0;
      end
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        half_d = half_n;
        if (state_q == GAP) begin
          if (half_q == GAP_LAST) begin
            state_d = FRAME_B;
            sync_d  = 1'b0;
            sh_d    = shb_q;
            half_d  = '0;
          end
        end else if (half_q == FRAME_LAST) begin
          state_d = state_q == FRAME_A ? GAP : IDLE;
          sync_d  = 1'b1;
          sclk_d  = 1'b1;
          half_d  = '0;
        end else if (half_n > HW'(1)) begin
          sclk_d = half_n[0];
          sh_d   = half_n[0] ? {sh_q[SHIFT_WIDTH-2:0], 1'b0} : sh_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= '0;
      sh_q    <= '0;
      shb_q   <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      sh_q    <= sh_d;
      shb_q   <= shb_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
    end
  end

  assign dacSync = sync_q;
  assign dacSclk = sclk_q;
  assign dacDin  = sh_q[SHIFT_WIDTH-1];
endmodule

// File: tb/tb_drv_ad56x3.sv
// tb_drv_ad56x3: decodes the DAC pins back into frames and checks them against frames built from the sample values.
`timescale 1ns/1ps
module tb_drv_ad56x3;
  localparam int DW = 14, DIV = 2, SD = 5;
  logic clk = 0, reset = 0, ce = 0;
  logic [DW-1:0] dataA = '0, dataB = '0;
  logic dacSync, dacSclk, dacDin;
  int checks = 0, failures = 0;
  logic [23:0] frames[$];
  int nb_q[$], lo_q[$], gap_q[$];
  logic [23:0] bits = '0;
  int nbits = 0, lo = 0, hi = 0, din_bad = 0, sclk_bad = 0, nfall = 0;
  logic p_sync = 1, p_sclk = 1, p_din = 0;

  always #20 clk = ~clk;

  drv_ad56x3 #(.SIGN_A("UNSIGNED"), .SIGN_B("SIGNED"), .DATA_WIDTH(DW),
               .SCLK_DIVIDER(DIV), .SYNC_DURATION(SD)) dut (
    .clk(clk), .reset(reset), .ce(ce), .dataA(dataA), .dataB(dataB),
    .dacSync(dacSync), .dacSclk(dacSclk), .dacDin(dacDin));

  // Pin-level DAC model: shifts DIN on falling SCLK inside a SYNC-low window.
  always @(negedge clk) begin
    if (!reset) begin
      bits = '0; nbits = 0; lo = 0; hi = 0;
    end else if (!dacSync) begin
      if (p_sync) begin gap_q.push_back(hi); nfall++; end
      lo++;
      if (p_sclk && !dacSclk) begin
        bits = {bits[22:0], dacDin}; nbits++;
        if (dacDin !== p_din) din_bad++;
      end
      if (!p_sync && !p_sclk && !dacSclk && dacDin !== p_din) din_bad++;
    end else begin
      if (!p_sync) begin
        frames.push_back(bits); nb_q.push_back(nbits); lo_q.push_back(lo);
        bits = '0; nbits = 0; lo = 0; hi = 0;
      end else if (dacSclk !== p_sclk) sclk_bad++;
      hi++;
    end
    p_sync = dacSync; p_sclk = dacSclk; p_din = dacDin;
  end

  function automatic logic [23:0] exp_frame(input bit ch_b, input logic [DW-1:0] d);
    int v;
    v = ch_b ? (int'(d) + 2**(DW-1)) % 2**DW : int'(d);
    return {2'b00, ch_b ? 3'b010 : 3'b000, ch_b ? 3'b001 : 3'b000, 16'(v * 2**(16-DW))};
  endfunction

  task automatic strobe(input logic [DW-1:0] a, input logic [DW-1:0] b);
    dataA = a; dataB = b; ce = 1;
    @(posedge clk); #5;
    ce = 0; dataA = DW'($urandom); dataB = DW'($urandom);
  endtask

  task automatic pulse(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(posedge clk); #5;
    strobe(a, b);
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int t = 0;
    while (frames.size() < n && t < 1000) begin @(posedge clk); t++; end
    ok = frames.size() >= n;
  endtask

  task automatic flush();
    frames.delete(); nb_q.delete(); lo_q.delete(); gap_q.delete();
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(posedge clk);
    #5 ce = 1; dataA = 14'h1234;
    @(negedge clk);
    checks++;
    if ({dacSync, dacSclk, dacDin} !== 3'b110) begin
      failures++; $display("FAIL reset_outputs got=%b want=110", {dacSync, dacSclk, dacDin});
    end
    ce = 0;
    @(posedge clk); #5 reset = 1;
    repeat (20) @(posedge clk);
    checks++;
    if (frames.size() != 0 || nfall != 0) begin
      failures++; $display("FAIL reset_idle frames=%0d falls=%0d want=0", frames.size(), nfall);
    end
  endtask

  task automatic test_vectors();
    logic [DW-1:0] va[2] = '{14'h3FFF, 14'h0000};
    logic [DW-1:0] vb[2] = '{14'h2000, 14'h1FFF};
    bit ok;
    for (int i = 0; i < 2; i++) begin
      flush();
      pulse(va[i], vb[i]);
      wait_frames(2, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL vec%0d_timeout frames=%0d want=2", i, frames.size()); continue; end
      checks++;
      if (frames[0] !== exp_frame(0, va[i])) begin
        failures++; $display("FAIL vec%0d_frameA got=%h want=%h", i, frames[0], exp_frame(0, va[i]));
      end
      checks++;
      if (frames[1] !== exp_frame(1, vb[i])) begin
        failures++; $display("FAIL vec%0d_frameB got=%h want=%h", i, frames[1], exp_frame(1, vb[i]));
      end
      checks++;
      if (nb_q[0] != 24 || nb_q[1] != 24) begin
        failures++; $display("FAIL vec%0d_bitcount got=%0d,%0d want=24", i, nb_q[0], nb_q[1]);
      end
    end
    checks++;
    if (exp_frame(0, 14'h3FFF) !== 24'h00FFFC || exp_frame(1, 14'h1FFF) !== 24'h11FFFC) begin
      failures++; $display("FAIL model_vectors got=%h,%h want=00fffc,11fffc", exp_frame(0, 14'h3FFF), exp_frame(1, 14'h1FFF));
    end
  endtask

  task automatic test_timing();
    bit ok;
    flush();
    pulse(DW'($urandom), DW'($urandom));
    wait_frames(2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL timing_timeout frames=%0d want=2", frames.size()); return; end
    checks++;
    if (lo_q[0] != 25 * DIV || lo_q[1] != 25 * DIV) begin
      failures++; $display("FAIL sync_low_len got=%0d,%0d want=%0d", lo_q[0], lo_q[1], 25 * DIV);
    end
    checks++;
    if (gap_q.size() != 2 || gap_q[1] != SD * DIV) begin
      failures++; $display("FAIL gap_len got=%0d want=%0d", gap_q.size() == 2 ? gap_q[1] : -1, SD * DIV);
    end
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (dacSclk !== 1'b1 || dacSync !== 1'b1 || dacDin !== 1'b0) begin
        failures++; $display("FAIL idle_pins got=%b%b%b want=110", dacSync, dacSclk, dacDin);
      end
    end
  endtask

  task automatic test_ce_ignored();
    logic [DW-1:0] a1 = 14'h2A5C, b1 = 14'h15A3, a2 = 14'h3333, b2 = 14'h0CCC, a3 = 14'h0F0F, b3 = 14'h30F0;
    bit ok;
    flush();
    pulse(a1, b1);
    repeat (19) @(posedge clk);
    #5 strobe(a2, b2);
    repeat (89) @(posedge clk);
    #5 strobe(a2, b2);
    #5 strobe(a3, b3);
    wait_frames(4, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ce_timeout frames=%0d want=4", frames.size()); return; end
    repeat (200) @(posedge clk);
    checks++;
    if (frames.size() != 4) begin failures++; $display("FAIL ce_extra_frames got=%0d want=4", frames.size()); end
    checks++;
    if (frames[0] !== exp_frame(0, a1) || frames[1] !== exp_frame(1, b1)) begin
      failures++; $display("FAIL ce_first_pair got=%h,%h want=%h,%h", frames[0], frames[1], exp_frame(0, a1), exp_frame(1, b1));
    end
    checks++;
    if (frames[2] !== exp_frame(0, a3) || frames[3] !== exp_frame(1, b3)) begin
      failures++; $display("FAIL ce_first_idle_cycle got=%h,%h want=%h,%h", frames[2], frames[3], exp_frame(0, a3), exp_frame(1, b3));
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] a = 14'h1C3E, b = 14'h3FFF;
    bit ok;
    int f0;
    flush();
    pulse(a, b);
    wait_frames(1, ok);
    repeat (31) @(posedge clk);
    #7 reset = 0;
    #1;
    checks++;
    if ({dacSync, dacSclk, dacDin} !== 3'b110) begin
      failures++; $display("FAIL reset_midframe_pins got=%b want=110", {dacSync, dacSclk, dacDin});
    end
    repeat (3) @(posedge clk);
    #5 reset = 1;
    f0 = nfall;
    repeat (300) @(posedge clk);
    checks++;
    if (!ok || frames.size() != 1 || nfall != f0) begin
      failures++; $display("FAIL reset_quiet frames=%0d extra_windows=%0d want=1,0", frames.size(), nfall - f0);
    end
    checks++;
    if (frames.size() < 1 || frames[0] !== exp_frame(0, a)) begin
      failures++; $display("FAIL reset_frameA got=%h want=%h", frames.size() ? frames[0] : 24'hx, exp_frame(0, a));
    end
    flush();
    pulse(b, a);
    wait_frames(2, ok);
    checks++;
    if (!ok || frames[0] !== exp_frame(0, b) || frames[1] !== exp_frame(1, a)) begin
      failures++; $display("FAIL after_reset_conv frames=%0d want pair %h,%h", frames.size(), exp_frame(0, b), exp_frame(1, a));
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b;
    logic [23:0] fa, fb;
    flush();
    for (int i = 0; i < 110; i++) begin
      a = DW'($urandom); b = DW'($urandom);
      pulse(a, b);
      repeat (123) @(posedge clk);
      checks++;
      if (frames.size() != 2) begin
        failures++; $display("FAIL rand%0d_count got=%0d want=2", i, frames.size()); flush(); continue;
      end
      fa = frames.pop_front(); fb = frames.pop_front();
      checks++;
      if (fa !== exp_frame(0, a) || fb !== exp_frame(1, b)) begin
        failures++; $display("FAIL rand%0d_pair got=%h,%h want=%h,%h", i, fa, fb, exp_frame(0, a), exp_frame(1, b));
      end
      flush();
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (din_bad != 0) begin failures++; $display("FAIL din_stability got=%0d want=0", din_bad); end
    checks++;
    if (sclk_bad != 0) begin failures++; $display("FAIL sclk_while_sync_high got=%0d want=0", sclk_bad); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_timing();
    test_ce_ignored();
    test_reset_midframe();
    test_random();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/drv_ad56x3.md
Name: drv_ad56x3

Overview:
- Serial driver for the AD56x3 dual-channel SPI DAC (AD5623/AD5643/AD5663).
- On each clock-enable strobe it captures two samples, dataA and dataB.
- It sends them as two consecutive 24-bit frames on the SYNC/SCLK/DIN interface: channel A first, then channel B.
- Sits between the sample-rate datapath and the DAC pins.

Parameters:
- SIGN_A, "UNSIGNED", coding of dataA: "UNSIGNED" (straight binary) or "SIGNED" (two's complement, converted to offset binary).
- SIGN_B, "SIGNED", same as SIGN_A for dataB.
- DATA_WIDTH, 14, sample width (12, 14 or 16; must be ≤16).
- SCLK_DIVIDER, 2, SCLK period in clk cycles; even, ≥2; each SCLK half-period is SCLK_DIVIDER/2 clk cycles.
- SYNC_DURATION, 5, number of SCLK periods dacSync is held high between frame A and frame B.
- Localparams (fixed, visible hierarchically): COMMAND_WORD_A=3'b000 (write input register), ADDRESS_WORD_A=3'b000 (DAC A), COMMAND_WORD_B=3'b010 (write input register, update all), ADDRESS_WORD_B=3'b001 (DAC B), SHIFT_WIDTH=24.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low.
- ce  in  1  one-clk start strobe; samples dataA/dataB when asserted while idle.
- dataA  in  DATA_WIDTH  channel A sample.
- dataB  in  DATA_WIDTH  channel B sample.
- dacSync  out  1  DAC SYNC, active-low frame enable.
- dacSclk  out  1  DAC serial clock; idles high.
- dacDin  out  1  DAC serial data, MSB first.

Behaviour:
- Reset (reset=0): dacSync=1, dacSclk=1, dacDin=0, state IDLE, shift registers cleared, divider counter cleared. Takes effect immediately, including mid-frame; after release the block waits for the next ce.
- IDLE: outputs at their reset values. On ce=1, register both frames in that clk edge, then go to FRAME_A. Inputs may be X from the next cycle onward.
- Data conversion: MSB' = MSB XOR 1 when the channel is "SIGNED", unchanged when "UNSIGNED"; remaining bits pass through.
- Data word = {MSB', data[DATA_WIDTH-2:0], (16-DATA_WIDTH) zeros}, i.e. left-justified in 16 bits.
- Frame layout = {2'b00, COMMAND_WORD, ADDRESS_WORD, 16-bit data word}, 24 bits, transmitted MSB first.
- FRAME_x:
  - dacSync goes low with dacDin = frame bit 23 and dacSclk high, held for one SCLK period (setup).
  - Then 24 bit periods follow, each: dacSclk falls (the DAC samples on the falling edge), is low for SCLK_DIVIDER/2 clk, rises, is high for SCLK_DIVIDER/2 clk.
  - dacDin changes to the next bit only at the rising dacSclk edge, never at a falling edge.
  - After the 24th rising edge, dacSync returns high with dacSclk high.
- GAP: after frame A, dacSync stays high and dacSclk stays high for SYNC_DURATION SCLK periods, then FRAME_B.
- After frame B, return to IDLE with dacDin=0.
- Exactly 24 falling dacSclk edges per dacSync-low window; no dacSclk edges while dacSync is high.
- Busy time per conversion: (50 + SYNC_DURATION) × SCLK_DIVIDER clk cycles. ce asserted while not IDLE is ignored; there is no queuing.
- ce coincident with the return to IDLE is ignored; ce is accepted from the first cycle in IDLE.
- All outputs come directly from flip-flops (glitch-free).

Test Plan:
- Default parameters: dataA=14'h3FFF, dataB=14'h2000, one ce → frame A = 24'h00FFFC, frame B = 24'h110000 (when sampled at falling dacSclk while dacSync=0).
- dataA=14'h0000, dataB=14'h1FFF → frame A = 24'h000000, frame B = 24'h11FFFC.
- Timing check at SCLK_DIVIDER=2, SYNC_DURATION=5:
  - each dacSync-low window lasts 50 clk;
  - the gap between windows is 10 clk high;
  - dacDin is stable across every falling dacSclk edge;
  - dacSclk idles high.
- ce re-pulsed mid-frame → ignored; the current frames complete unchanged; the next ce after IDLE starts a new conversion.
- reset asserted during frame B → dacSync=1, dacSclk=1, dacDin=0 immediately; after release there is no activity until ce.
- Random dataA/dataB at a 200 kHz ce rate with 25 MHz clk for ≥100 conversions → every frame pair matches the conversion/frame formula above.
